// File: rtl/clock_cont_pkg.sv
// Shared types and constants for the clock_cont user-control front end.
package clock_cont_pkg;

    localparam int unsigned PERIOD_W   = 4;
    localparam int unsigned DUTY_W     = 2;
    localparam int unsigned PERIOD_MIN = 1;
    localparam int unsigned PERIOD_MAX = 15;
    localparam int unsigned DUTY_MAX   = 3;

    typedef enum logic {
        FIELD_PERIOD = 1'b0,
        FIELD_DUTY   = 1'b1
    } field_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Counter width for a terminal count, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, debounce counter and
// single-cycle rising-edge press pulse.
module btn_debounce
    import clock_cont_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             dly_q, dly_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            dly_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            dly_q   <= dly_d;
            press_q <= press_d;
        end
    end

    // Count consecutive cycles the synchronised input disagrees with the level.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = '0;
        level_d = level_q;
        dly_d   = level_q;
        press_d = level_q & ~dly_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_cont_ctrl.sv
// Push-button front end producing period/duty settings for the clock generator.
// Optional auto-repeat on held up/down is enabled by CLOCK_CONT_AUTOREPEAT_EN.
module clock_cont_ctrl
    import clock_cont_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000,
    parameter int unsigned PERIOD_RESET    = 1,
    parameter int unsigned DUTY_RESET      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_sel,
    output logic [PERIOD_W-1:0] period,
    output logic [DUTY_W-1:0]   duty,
    output logic                field_sel,
    output logic                changed
);

    logic up_lvl, up_prs, dn_lvl, dn_prs, sel_lvl, sel_prs;
    logic rep_up_c, rep_dn_c;
    logic unused_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_up),   .level(up_lvl),  .press(up_prs)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .level(dn_lvl),  .press(dn_prs)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_sel),  .level(sel_lvl), .press(sel_prs)
    );

`ifdef CLOCK_CONT_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = clog2_min1(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    rep_state_e       state_q, state_d;
    logic [REP_W-1:0] rcnt_q, rcnt_d;
    logic             dir_up_q, dir_up_d;
    logic             rep_exit_c;

    // Leave repeat when the tracked button releases or both are held.
    assign rep_exit_c = (dir_up_q ? ~up_lvl : ~dn_lvl) | (up_lvl & dn_lvl);
    assign unused_c   = sel_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            dir_up_q <= dir_up_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        dir_up_d = dir_up_q;
        case (state_q)
            IDLE: begin
                if (up_prs || dn_prs) begin
                    state_d  = HOLD;
                    rcnt_d   = '0;
                    dir_up_d = up_prs;
                end
            end
            HOLD: begin
                if (rep_exit_c) begin
                    state_d = IDLE;
                end else if (rcnt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + REP_W'(1);
                end
            end
            REPEAT: begin
                if (rep_exit_c) begin
                    state_d = IDLE;
                end else if (rcnt_q == RATE_LAST) begin
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + REP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rep_up_c = 1'b0;
        rep_dn_c = 1'b0;
        if (!rep_exit_c &&
            (((state_q == HOLD)   && (rcnt_q == DELAY_LAST)) ||
             ((state_q == REPEAT) && (rcnt_q == RATE_LAST)))) begin
            rep_up_c = dir_up_q;
            rep_dn_c = ~dir_up_q;
        end
    end
`else
    assign rep_up_c = 1'b0;
    assign rep_dn_c = 1'b0;
    assign unused_c = ^{sel_lvl, up_lvl, dn_lvl, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    field_e              field_q, field_d;
    logic                changed_q, changed_d;
    logic                up_step_c, dn_step_c, inc_c, dec_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= PERIOD_W'(PERIOD_RESET);
            duty_q    <= DUTY_W'(DUTY_RESET);
            field_q   <= FIELD_PERIOD;
            changed_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            duty_q    <= duty_d;
            field_q   <= field_d;
            changed_q <= changed_d;
        end
    end

    // Saturating step on the field selected before any same-cycle toggle.
    always_comb begin
        up_step_c = up_prs | rep_up_c;
        dn_step_c = dn_prs | rep_dn_c;
        inc_c     = up_step_c & ~dn_step_c;
        dec_c     = dn_step_c & ~up_step_c;
        period_d  = period_q;
        duty_d    = duty_q;
        field_d   = sel_prs ? ((field_q == FIELD_PERIOD) ? FIELD_DUTY : FIELD_PERIOD) : field_q;
        if (field_q == FIELD_PERIOD) begin
            if (inc_c && (period_q != PERIOD_W'(PERIOD_MAX))) begin
                period_d = period_q + PERIOD_W'(1);
            end else if (dec_c && (period_q != PERIOD_W'(PERIOD_MIN))) begin
                period_d = period_q - PERIOD_W'(1);
            end
        end else begin
            if (inc_c && (duty_q != DUTY_W'(DUTY_MAX))) begin
                duty_d = duty_q + DUTY_W'(1);
            end else if (dec_c && (duty_q != '0)) begin
                duty_d = duty_q - DUTY_W'(1);
            end
        end
        changed_d = (period_d != period_q) || (duty_d != duty_q);
    end

    assign period    = period_q;
    assign duty      = duty_q;
    assign field_sel = (field_q == FIELD_DUTY);
    assign changed   = changed_q;

endmodule

// File: tb/tb_clock_cont_ctrl.sv
// Directed self-checking bench for clock_cont_ctrl (short debounce/repeat intervals).
// Auto-repeat checks run only when CLOCK_CONT_AUTOREPEAT_EN is defined.
module tb_clock_cont_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn;          // {sel, down, up}
    logic [3:0] period;
    logic [1:0] duty;
    logic       field_sel;
    logic       changed;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_cnt  = 0;
    int chg_base = 0;

`ifdef CLOCK_CONT_AUTOREPEAT_EN
    localparam int HOLD_LEN = 12;
`else
    localparam int HOLD_LEN = 30;
`endif

    clock_cont_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .PERIOD_RESET(1),
        .DUTY_RESET(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn[0]),
        .btn_down(btn[1]),
        .btn_sel(btn[2]),
        .period(period),
        .duty(duty),
        .field_sel(field_sel),
        .changed(changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (changed === 1'b1) chg_cnt++;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [2:0] v);
        @(negedge clk);
        btn = v;
    endtask

    task automatic press(input logic [2:0] m);
        set_btn(btn | m);
        tick(12);
        set_btn(btn & ~m);
        tick(10);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 3'b000;
        tick(2);
        check("reset_period",  int'(period),    1);
        check("reset_duty",    int'(duty),      0);
        check("reset_field",   int'(field_sel), 0);
        check("reset_changed", int'(changed),   0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        check("idle_period",  int'(period),  1);
        check("idle_changed", int'(changed), 0);

        // press latency: raw edge to output update is DEBOUNCE+4 = 8 cycles
        chg_base = chg_cnt;
        set_btn(3'b001);
        tick(7);
        check("lat_before",  int'(period),  1);
        tick(1);
        check("lat_period",  int'(period),  2);
        check("lat_changed", int'(changed), 1);
        tick(1);
        check("lat_strobe_one_cycle", int'(changed), 0);
        tick(HOLD_LEN - 9);
        set_btn(3'b000);
        tick(10);
        check("lat_final",   int'(period),        2);
        check("lat_chg_cnt", chg_cnt - chg_base,  1);

        // bounce: toggle every 2 cycles never satisfies the debounce count
        chg_base = chg_cnt;
        for (int i = 0; i < 10; i++) begin
            set_btn((i % 2 == 0) ? 3'b001 : 3'b000);
            repeat (2) @(posedge clk);
        end
        set_btn(3'b000);
        tick(12);
        check("bounce_period",  int'(period),       2);
        check("bounce_chg_cnt", chg_cnt - chg_base, 0);

        // saturation on both fields
        pulse_reset();
        check("sat_reset_period", int'(period), 1);
        chg_base = chg_cnt;
        repeat (16) press(3'b001);
        check("sat_period_max", int'(period),       15);
        check("sat_up_chg_cnt", chg_cnt - chg_base, 14);
        chg_base = chg_cnt;
        press(3'b100);
        check("sel_field_duty", int'(field_sel),    1);
        check("sel_no_chg",     chg_cnt - chg_base, 0);
        repeat (2) press(3'b010);
        check("duty_min_hold",  int'(duty),         0);
        check("duty_dn_no_chg", chg_cnt - chg_base, 0);
        chg_base = chg_cnt;
        repeat (4) press(3'b001);
        check("duty_max",       int'(duty),         3);
        check("duty_up_chg",    chg_cnt - chg_base, 3);
        check("period_untouched", int'(period),     15);
        press(3'b100);
        check("sel_field_period", int'(field_sel), 0);
        chg_base = chg_cnt;
        repeat (15) press(3'b010);
        check("period_min",     int'(period),       1);
        check("period_dn_chg",  chg_cnt - chg_base, 14);

        // simultaneous up/down cancel; sel+up steps the old field then toggles
        chg_base = chg_cnt;
        press(3'b011);
        check("sim_period",  int'(period),       1);
        check("sim_duty",    int'(duty),         3);
        check("sim_no_chg",  chg_cnt - chg_base, 0);
        chg_base = chg_cnt;
        press(3'b101);
        check("selup_period", int'(period),       2);
        check("selup_field",  int'(field_sel),    1);
        check("selup_duty",   int'(duty),         3);
        check("selup_chg",    chg_cnt - chg_base, 1);

`ifdef CLOCK_CONT_AUTOREPEAT_EN
        // auto-repeat: press step, +20 cycles, then every 5 cycles
        pulse_reset();
        btn = 3'b000;
        tick(4);
        set_btn(3'b001);
        tick(8);
        check("ar_press",   int'(period), 2);
        tick(19);
        check("ar_hold",    int'(period), 3 - 1);
        tick(1);
        check("ar_first_rep", int'(period),  3);
        check("ar_first_chg", int'(changed), 1);
        tick(4);
        check("ar_rate_wait", int'(period), 3);
        tick(1);
        check("ar_second_rep", int'(period), 4);
        tick(5);
        check("ar_third_rep",  int'(period), 5);
        tick(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_rst_period",  int'(period),    1);
        check("ar_rst_duty",    int'(duty),      0);
        check("ar_rst_field",   int'(field_sel), 0);
        check("ar_rst_changed", int'(changed),   0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(7);
        check("ar_held_before", int'(period), 1);
        tick(1);
        check("ar_held_press",  int'(period), 2);
        set_btn(3'b000);
        tick(12);
        check("ar_held_final",  int'(period), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
